// File: rtl/dds_multi.sv
// rtl/dds_multi.sv - N_CH-channel DDS generator: one shared quarter-wave sine LUT, one unsigned mixed output sample.
// Optional feature: define DDS_DITHER_EN to add LFSR dither ahead of the output shift.
`timescale 1ns/1ps
module dds_multi #(
   parameter int N_CH    = 4,
   parameter int PHASE_W = 16,
   parameter int FREQ_W  = 12,
   parameter int SUB_W   = 10,
   parameter int OUT_W   = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SUB_W-1:0]      subsample_phase,
   input  logic                  cfg_we,
   input  logic [$clog2(N_CH):0] cfg_ch,
   input  logic [FREQ_W-1:0]     cfg_freq,
   input  logic [1:0]            cfg_mode,
   output logic [OUT_W-1:0]      out,
   output logic                  out_valid,
   output logic                  busy
);

   localparam int CH_W  = $clog2(N_CH);
   localparam int SUM_W = 8 + CH_W;
   localparam int SH    = CH_W + 8 - OUT_W;
   localparam int XW    = SUM_W + 2;

   localparam logic [1:0] MODE_OFF    = 2'b00;
   localparam logic [1:0] MODE_SINE   = 2'b01;
   localparam logic [1:0] MODE_SQUARE = 2'b10;
   localparam logic [1:0] MODE_SAW    = 2'b11;

   localparam logic signed [XW-1:0] OFFS_X  = XW'(1 << (OUT_W - 1));
   localparam logic signed [XW-1:0] OMAX_X  = XW'((1 << OUT_W) - 1);
   localparam logic [OUT_W-1:0]     OUT_MID = OUT_W'(1 << (OUT_W - 1));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CH_W-1:0]         k_q, k_d;
   logic signed [SUM_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0]        out_q, out_d;
   logic                    out_valid_q, out_valid_d;

   logic [PHASE_W-1:0] phase_q [N_CH];
   logic [FREQ_W-1:0]  freq_q  [N_CH];
   logic [1:0]         mode_q  [N_CH];

   // Quarter-wave table: round(127 * sin(pi/2 * i/63)), so entry 63 is the peak.
   function automatic logic [6:0] sine_rom(input logic [5:0] idx);
      logic [6:0] v;
      case (idx)
         6'd0:  v = 7'd0;   6'd1:  v = 7'd3;   6'd2:  v = 7'd6;   6'd3:  v = 7'd9;
         6'd4:  v = 7'd13;  6'd5:  v = 7'd16;  6'd6:  v = 7'd19;  6'd7:  v = 7'd22;
         6'd8:  v = 7'd25;  6'd9:  v = 7'd28;  6'd10: v = 7'd31;  6'd11: v = 7'd34;
         6'd12: v = 7'd37;  6'd13: v = 7'd40;  6'd14: v = 7'd43;  6'd15: v = 7'd46;
         6'd16: v = 7'd49;  6'd17: v = 7'd52;  6'd18: v = 7'd55;  6'd19: v = 7'd58;
         6'd20: v = 7'd61;  6'd21: v = 7'd64;  6'd22: v = 7'd66;  6'd23: v = 7'd69;
         6'd24: v = 7'd72;  6'd25: v = 7'd74;  6'd26: v = 7'd77;  6'd27: v = 7'd79;
         6'd28: v = 7'd82;  6'd29: v = 7'd84;  6'd30: v = 7'd86;  6'd31: v = 7'd89;
         6'd32: v = 7'd91;  6'd33: v = 7'd93;  6'd34: v = 7'd95;  6'd35: v = 7'd97;
         6'd36: v = 7'd99;  6'd37: v = 7'd101; 6'd38: v = 7'd103; 6'd39: v = 7'd105;
         6'd40: v = 7'd107; 6'd41: v = 7'd108; 6'd42: v = 7'd110; 6'd43: v = 7'd112;
         6'd44: v = 7'd113; 6'd45: v = 7'd114; 6'd46: v = 7'd116; 6'd47: v = 7'd117;
         6'd48: v = 7'd118; 6'd49: v = 7'd119; 6'd50: v = 7'd120; 6'd51: v = 7'd121;
         6'd52: v = 7'd122; 6'd53: v = 7'd123; 6'd54: v = 7'd124; 6'd55: v = 7'd124;
         6'd56: v = 7'd125; 6'd57: v = 7'd126; 6'd58: v = 7'd126; 6'd59: v = 7'd126;
         6'd60: v = 7'd127; 6'd61: v = 7'd127; 6'd62: v = 7'd127;
         default: v = 7'd127;
      endcase
      return v;
   endfunction

`ifdef DDS_DITHER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 16'hACE1;
      end else if (state_q == S_DONE) begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end
`endif

   logic [PHASE_W-1:0]      cur_p, phase_nxt;
   logic [FREQ_W-1:0]       cur_f;
   logic [1:0]              cur_m, quad;
   logic [5:0]              lut_idx;
   logic [7:0]              saw_b;
   logic signed [7:0]       lut_s, samp;
   logic signed [SUM_W-1:0] sum_next;

   assign cur_p = phase_q[k_q];
   assign cur_f = freq_q[k_q];
   assign cur_m = mode_q[k_q];

   always_comb begin
      quad    = cur_p[PHASE_W-1 -: 2];
      lut_idx = quad[0] ? ~cur_p[PHASE_W-3 -: 6] : cur_p[PHASE_W-3 -: 6];
      lut_s   = $signed({1'b0, sine_rom(lut_idx)});
      saw_b   = cur_p[PHASE_W-1 -: 8];
      case (cur_m)
         MODE_SINE:   samp = quad[1] ? -lut_s : lut_s;
         MODE_SQUARE: samp = cur_p[PHASE_W-1] ? -8'sd127 : 8'sd127;
         MODE_SAW:    samp = (saw_b == 8'h00) ? -8'sd127 : $signed({~saw_b[7], saw_b[6:0]});
         default:     samp = 8'sd0;
      endcase
   end

   // An idle channel parks at phase 0 so re-enabling it always starts cleanly.
   assign phase_nxt = (cur_m == MODE_OFF) ? '0 : cur_p + PHASE_W'(cur_f);
   assign sum_next  = acc_q + SUM_W'(samp);

   logic signed [XW-1:0] mix_x, mix_sh, mix_b;
   logic [OUT_W-1:0]     mix_out;

   always_comb begin
      mix_x = XW'(sum_next);
`ifdef DDS_DITHER_EN
      mix_x = mix_x + $signed(XW'(lfsr_q[SH-1:0]));
`endif
      mix_sh = mix_x >>> SH;
      mix_b  = mix_sh + OFFS_X;
      if (mix_b[XW-1]) begin
         mix_out = '0;
      end else if (mix_b > OMAX_X) begin
         mix_out = '1;
      end else begin
         mix_out = mix_b[OUT_W-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (subsample_phase == '0) begin
               state_d = S_RUN;
               k_d     = '0;
               acc_d   = '0;
            end
         end
         S_RUN: begin
            acc_d = sum_next;
            k_d   = k_q + CH_W'(1);
            if (&k_q) begin
               state_d     = S_DONE;
               out_d       = mix_out;
               out_valid_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         acc_q       <= '0;
         out_q       <= OUT_MID;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // A write landing on the channel being processed only affects the next round,
   // because this cycle's sample and phase step read the pre-write registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            freq_q[i] <= '0;
            mode_q[i] <= MODE_OFF;
         end
      end else if (cfg_we && !cfg_ch[CH_W]) begin
         freq_q[cfg_ch[CH_W-1:0]] <= cfg_freq;
         mode_q[cfg_ch[CH_W-1:0]] <= cfg_mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            phase_q[i] <= '0;
         end
      end else if (state_q == S_RUN) begin
         phase_q[k_q] <= phase_nxt;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dds_multi.sv
// tb/tb_dds_multi.sv - directed self-checking bench for dds_multi (default parameters).
`timescale 1ns/1ps
module tb_dds_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] subsample_phase;
   logic       cfg_we;
   logic [2:0] cfg_ch;
   logic [11:0] cfg_freq;
   logic [1:0] cfg_mode;
   logic [6:0] out;
   logic       out_valid;
   logic       busy;

   int total = 0;
   int bad   = 0;
   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   dds_multi dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .subsample_phase (subsample_phase),
      .cfg_we          (cfg_we),
      .cfg_ch          (cfg_ch),
      .cfg_freq        (cfg_freq),
      .cfg_mode        (cfg_mode),
      .out             (out),
      .out_valid       (out_valid),
      .busy            (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference mixer for the default build: shift 3, offset 64, clamp 0..127.
   function automatic int mix(input int sum);
      int v;
      int d;
      d = 0;
`ifdef DDS_DITHER_EN
      d = int'(m_lfsr[2:0]);
`endif
      v = ((sum + d) >>> 3) + 64;
      if (v < 0) v = 0;
      if (v > 127) v = 127;
      return v;
   endfunction

   task automatic m_step();
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = 16'hACE1;
   endtask

   task automatic cfg_write(input logic [2:0] ch, input logic [11:0] f, input logic [1:0] m);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = ch; cfg_freq = f; cfg_mode = m;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // One round; optional config write at negedge index wr_at (1 = channel 0's RUN cycle).
   task automatic run_round(input int wr_at, input logic [2:0] wch, input logic [11:0] wf,
                            input logic [1:0] wm, output logic [6:0] o, output int lat);
      int n;
      @(negedge clk);
      subsample_phase = 10'd0;
      @(negedge clk);
      subsample_phase = 10'd1;
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin
         if (n == wr_at) begin
            cfg_we = 1'b1; cfg_ch = wch; cfg_freq = wf; cfg_mode = wm;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      cfg_we = 1'b0;
      chk("round_valid", out_valid, 1);
      lat = n;
      o   = out;
   endtask

   task automatic round(output logic [6:0] o);
      int lat;
      run_round(-1, 3'd0, 12'd0, 2'd0, o, lat);
   endtask

   initial begin
      logic [6:0] o;
      int lat;
      int cnt;
      int pos;

      rst_n = 1'b0; subsample_phase = 10'd1;
      cfg_we = 1'b0; cfg_ch = 3'd0; cfg_freq = 12'd0; cfg_mode = 2'd0;
      m_lfsr = 16'hACE1;
      repeat (2) @(negedge clk);
      chk("rst_out", out, 64);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      // All square at phase 0: 4 * 127
      for (int c = 0; c < 4; c++) cfg_write(3'(c), 12'd0, 2'b10);
      run_round(-1, 3'd0, 12'd0, 2'd0, o, lat);
      chk("sq_out", o, mix(508));
      chk("sq_lat", lat, 5);
      m_step();
      round(o); chk("sq_out2", o, mix(508)); m_step();

      // All saw at phase 0: 4 * -127
      for (int c = 0; c < 4; c++) cfg_write(3'(c), 12'd0, 2'b11);
      round(o); chk("saw_out", o, mix(-508)); m_step();

      // Trigger held low for 3 cycles: one round only
      @(negedge clk);
      subsample_phase = 10'd0;
      cnt = 0; pos = -1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 3) subsample_phase = 10'd1;
         if (out_valid === 1'b1) begin
            cnt++;
            if (pos < 0) pos = i;
         end
      end
      chk("hold_cnt", cnt, 1);
      chk("hold_pos", pos, 5);
      repeat (cnt) m_step();

      // Out-of-range channel write must not alias onto ch1
      cfg_write(3'd5, 12'd0, 2'b10);
      round(o); chk("bad_ch", o, mix(-508)); m_step();

      // ch0 saw freq 0x400, others off
      for (int c = 1; c < 4; c++) cfg_write(3'(c), 12'd0, 2'b00);
      cfg_write(3'd0, 12'h400, 2'b11);
      round(o); chk("wr_a", o, mix(-127)); m_step();
      run_round(1, 3'd0, 12'hC00, 2'b11, o, lat);
      chk("wr_b", o, mix(-124)); m_step();
      round(o); chk("wr_c_old_inc", o, mix(-120)); m_step();
      round(o); chk("wr_d_new_inc", o, mix(-108)); m_step();

      // Mode off clears phase
      cfg_write(3'd0, 12'hC00, 2'b00);
      round(o); chk("off_out", o, mix(0)); m_step();
      cfg_write(3'd0, 12'd0, 2'b11);
      round(o); chk("reenable", o, mix(-127)); m_step();

      // Asynchronous reset mid-round
      for (int c = 0; c < 4; c++) cfg_write(3'(c), 12'd0, 2'b10);
      round(o); chk("pre_rst", o, mix(508)); m_step();
      @(negedge clk); subsample_phase = 10'd0;
      @(negedge clk); subsample_phase = 10'd1;
      @(negedge clk);
      #2;
      chk("busy_mid", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_out", out, 64);
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = 16'hACE1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) cnt++;
      end
      chk("abort_novalid", cnt, 0);
      round(o); chk("post_rst", o, mix(0)); m_step();

      // ch0 sine 0x400: peak at round 17, period 64 rounds
      cfg_write(3'd0, 12'h400, 2'b01);
      for (int r = 1; r <= 65; r++) begin
         round(o);
         case (r)
            1:  chk("sine_r1", o, mix(0));
            17: chk("sine_r17", o, mix(127));
            33: chk("sine_r33", o, mix(0));
            49: chk("sine_r49", o, mix(-127));
            65: chk("sine_r65", o, mix(0));
            default: ;
         endcase
         m_step();
      end

      // Dither (or plain truncation): ch0 saw at phase 0
      do_reset();
      cfg_write(3'd0, 12'd0, 2'b11);
      for (int r = 0; r < 20; r++) begin
         round(o);
         chk("dith_out", o, mix(-127));
         chk("dith_rng", (o >= 7'd48 && o <= 7'd49), 1);
         m_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
